// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB3 completer with ID/CTRL/SCRATCH registers, a free-running timer,
// an 8-entry word FIFO and per-transfer programmable wait states.
module apb_reg_completer #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hA9B0_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o
);
  typedef enum logic {IDLE, ACCESS} state_e;
  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  timer_en_q, timer_en_d;
  logic [3:0]            wait_cfg_q, wait_cfg_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [31:0]           timer_q, timer_d;
  logic [DATA_WIDTH-1:0] fifo_q [8];
  logic [DATA_WIDTH-1:0] fifo_d [8];
  logic [2:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [11:0]           off;
  logic                  unused_addr;
  logic                  full, empty, err, pready, commit, push, pop, wr_ctrl;
  logic [DATA_WIDTH-1:0] rdata;

  assign off         = paddr_i[11:0];
  assign unused_addr = ^paddr_i[ADDR_WIDTH-1:12];
  assign full        = cnt_q == 4'd8;
  assign empty       = cnt_q == 4'd0;

  always_comb begin
    err = (off[1:0] != 2'b00) || (off > 12'h014)
       || (pwrite_i && (off == 12'h000 || off == 12'h00C || off == 12'h014))
       || (pwrite_i && off == 12'h010 && full)
       || (!pwrite_i && off == 12'h010 && empty);
    rdata = off == 12'h000 ? DATA_WIDTH'(ID_VALUE)
          : off == 12'h004 ? DATA_WIDTH'({wait_cfg_q, 3'b000, timer_en_q})
          : off == 12'h008 ? scratch_q
          : off == 12'h00C ? DATA_WIDTH'(timer_q)
          : off == 12'h010 ? fifo_q[rptr_q]
          : DATA_WIDTH'({full, empty, 4'b0000, cnt_q});
    pready  = state_q == ACCESS && psel_i && wcnt_q == 4'd0;
    commit  = pready && penable_i && !err;
    push    = commit && pwrite_i && off == 12'h010;
    pop     = commit && !pwrite_i && off == 12'h010;
    wr_ctrl = commit && pwrite_i && off == 12'h004;
  end

  assign pready_o  = pready;
  assign pslverr_o = pready && err;
  assign prdata_o  = (pready && !pwrite_i && !err) ? rdata : '0;

  // Counter reloads continuously in IDLE, so wait_cfg is captured on the setup edge.
  always_comb begin
    state_d = state_q == IDLE ? ((psel_i && !penable_i) ? ACCESS : IDLE)
                              : ((psel_i && wcnt_q != 4'd0) ? ACCESS : IDLE);
    wcnt_d  = state_q == IDLE ? wait_cfg_q : (wcnt_q != 4'd0 ? wcnt_q - 4'd1 : 4'd0);
  end

  always_comb begin
    timer_en_d = wr_ctrl ? pwdata_i[0] : timer_en_q;
    wait_cfg_d = wr_ctrl ? pwdata_i[7:4] : wait_cfg_q;
    scratch_d  = (commit && pwrite_i && off == 12'h008) ? pwdata_i : scratch_q;
    timer_d    = (wr_ctrl && pwdata_i[1]) ? '0 : timer_q + 32'(timer_en_q);
    fifo_d     = fifo_q;
    if (push) fifo_d[wptr_q] = pwdata_i;
    wptr_d     = wptr_q + 3'(push);
    rptr_d     = rptr_q + 3'(pop);
    cnt_d      = cnt_q + 4'(push) - 4'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      timer_en_q <= 1'b0;
      wait_cfg_q <= '0;
      scratch_q  <= '0;
      timer_q    <= '0;
      fifo_q     <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      timer_en_q <= timer_en_d;
      wait_cfg_q <= wait_cfg_d;
      scratch_q  <= scratch_d;
      timer_q    <= timer_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_apb_reg_completer.sv
// tb_apb_reg_completer: directed plus randomized APB traffic checked every cycle against
// a transaction-level model of the register map, timer and FIFO.
module tb_apb_reg_completer;
  logic        clk = 0, rst_n = 0;
  logic [31:0] paddr = 0, pwdata = 0, prdata;
  logic        psel = 0, penable = 0, pwrite = 0, pready, pslverr;
  int          checks = 0, errors = 0;
  int unsigned cyc = 0;
  logic        want_rdy = 0, want_err = 0;
  logic [31:0] want_rd = 0;
  logic        m_en;
  logic [3:0]  m_wait;
  logic [31:0] m_scratch, t0;
  int unsigned c0;
  logic [31:0] q[$];
  logic [31:0] g_rd;
  bit          g_err;
  int          g_lat;

  apb_reg_completer dut (
    .clk(clk), .rst_n(rst_n), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, want, cyc);
    end
  endfunction

  always @(negedge clk) if (rst_n) begin
    check("pready", {31'b0, pready}, {31'b0, want_rdy});
    check("pslverr", {31'b0, pslverr}, {31'b0, want_err});
    check("prdata", prdata, want_rd);
  end

  // Timer is a linear function of the cycle count since the last CTRL rebase.
  function automatic logic [31:0] m_timer();
    return t0 + (m_en ? 32'(cyc - c0) : 32'd0);
  endfunction

  function automatic void m_reset();
    m_en = 0; m_wait = 0; m_scratch = 0; t0 = 0; c0 = cyc; q.delete();
  endfunction

  function automatic void m_eval(input logic [31:0] a, input bit wr, output bit err, output logic [31:0] rd);
    logic [11:0] off = a[11:0];
    err = off[1:0] != 0 || off > 12'h014 || (wr && (off == 12'h000 || off == 12'h00C || off == 12'h014))
       || (wr && off == 12'h010 && q.size() == 8) || (!wr && off == 12'h010 && q.size() == 0);
    rd = 0;
    if (!err && !wr)
      case (off)
        12'h000: rd = 32'hA9B0_0001;
        12'h004: rd = {24'b0, m_wait, 3'b0, m_en};
        12'h008: rd = m_scratch;
        12'h00C: rd = m_timer();
        12'h010: rd = q[0];
        default: rd = {22'b0, q.size() == 8, q.size() == 0, 4'b0, 4'(q.size())};
      endcase
  endfunction

  function automatic void m_commit(input logic [31:0] a, input bit wr, input logic [31:0] wd);
    logic [11:0] off = a[11:0];
    if (wr)
      case (off)
        12'h004: begin
          t0 = wd[1] ? 32'd0 : m_timer() + {31'b0, m_en};
          c0 = cyc + 1; m_en = wd[0]; m_wait = wd[7:4];
        end
        12'h008: m_scratch = wd;
        12'h010: q.push_back(wd);
        default: ;
      endcase
    else if (off == 12'h010) void'(q.pop_front());
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd, input int abort_at,
                      output logic [31:0] rd, output bit err, output int lat);
    bit e; logic [31:0] r; int w;
    paddr = a; pwrite = wr; pwdata = wd; psel = 1; penable = 0;
    @(posedge clk); #1;
    penable = 1; w = m_wait; lat = 0;
    for (int i = 0; i < w; i++) begin
      if (i == abort_at) begin
        psel = 0; penable = 0;
        @(posedge clk); #1;
        rd = 0; err = 0;
        return;
      end
      @(negedge clk); if (!pready) lat++;
      @(posedge clk); #1;
    end
    m_eval(a, wr, e, r);
    want_rdy = 1; want_err = e; want_rd = r;
    if (!e) m_commit(a, wr, wd);
    @(negedge clk); rd = prdata; err = pslverr; if (!pready) lat++;
    @(posedge clk); #1;
    want_rdy = 0; want_err = 0; want_rd = 0; psel = 0; penable = 0;
  endtask

  task automatic do_x(input logic [31:0] a, input bit wr, input logic [31:0] wd);
    xfer(a, wr, wd, -1, g_rd, g_err, g_lat);
  endtask

  initial begin
    logic [31:0] a, wd;
    bit wr;
    int ab;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1; m_reset();
    check("rst_pready", {31'b0, pready}, 0);
    check("rst_pslverr", {31'b0, pslverr}, 0);
    check("rst_prdata", prdata, 0);
    idle(1);
    do_x(0, 0, 0);
    check("id_val", g_rd, 32'hA9B0_0001); check("id_err", {31'b0, g_err}, 0); check("id_lat", g_lat, 0);
    do_x(4, 1, 32'h30);     check("ctrl_wr_lat", g_lat, 0);
    do_x(8, 0, 0);          check("scr_lat", g_lat, 3); check("scr_val", g_rd, 0);
    do_x(4, 1, 0);
    for (int i = 1; i <= 8; i++) do_x(32'h10, 1, 32'h11 * i);
    do_x(32'h10, 1, 32'h99); check("push_full_err", {31'b0, g_err}, 1);
    do_x(32'h14, 0, 0);      check("stat_full", g_rd, 32'h208);
    for (int i = 1; i <= 8; i++) begin do_x(32'h10, 0, 0); check("pop_order", g_rd, 32'h11 * i); end
    do_x(32'h14, 0, 0);      check("stat_empty", g_rd, 32'h100);
    do_x(32'h10, 0, 0);      check("pop_empty_err", {31'b0, g_err}, 1); check("pop_empty_rd", g_rd, 0);
    do_x(4, 1, 1); idle(10);
    do_x(32'hC, 0, 0);       check("timer_run", g_rd, 11);
    do_x(4, 1, 3);
    do_x(32'hC, 0, 0);       check("timer_clr_small", {31'b0, g_rd <= 2}, 1);
    do_x(4, 0, 0);           check("ctrl_rd", g_rd, 1);
    do_x(4, 1, 0);
    do_x(32'h18, 0, 0);      check("unmapped_err", {31'b0, g_err}, 1);
    do_x(32'h6, 0, 0);       check("misalign_err", {31'b0, g_err}, 1); check("misalign_rd", g_rd, 0);
    do_x(0, 1, 32'h1234);    check("id_wr_err", {31'b0, g_err}, 1);
    do_x(0, 0, 0);           check("id_intact", g_rd, 32'hA9B0_0001);
    do_x(8, 1, 32'h5A5A);
    do_x(32'hA, 1, 32'h1111);
    do_x(8, 0, 0);           check("scr_intact", g_rd, 32'h5A5A);
    do_x(4, 1, 32'h50);
    paddr = 8; pwrite = 1; pwdata = 32'hDEAD_BEEF; psel = 1; penable = 0;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 rst_n = 0;
    #1;
    check("arst_pready", {31'b0, pready}, 0);
    check("arst_pslverr", {31'b0, pslverr}, 0);
    check("arst_prdata", prdata, 0);
    psel = 0; penable = 0; m_reset();
    idle(2);
    rst_n = 1; m_reset();
    do_x(8, 0, 0);           check("scr_after_rst", g_rd, 0);
    do_x(4, 0, 0);           check("ctrl_after_rst", g_rd, 0);
    repeat (300) begin
      case ($urandom_range(0, 9))
        0: a = 0;
        1: a = 4;
        2: a = 8;
        3: a = 12;
        4, 5, 6: a = 32'h10;
        7: a = 32'h14;
        8: a = 32'h18 + 4 * $urandom_range(0, 100);
        default: a = 4 * $urandom_range(0, 5) + $urandom_range(1, 3);
      endcase
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 4) wd = wd & 32'hFFFF_FF3F;
      ab = (m_wait > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, m_wait - 1)) : -1;
      xfer(a, wr, wd, ab, g_rd, g_err, g_lat);
      idle($urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
